// File: rtl/cache_mgmt_unit_pkg.sv
// Shared definitions for the split L1 cache controller: FSM encodings,
// block geometry and the store byte-lane merge.
package cache_mgmt_unit_pkg;

   localparam int ADDR_W          = 30;
   localparam int BLOCK_W         = 256;
   localparam int WORDS_PER_BLOCK = 8;
   localparam int OFFSET_W        = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DC_WB   = 3'd1,
      S_DC_FILL = 3'd2,
      S_IC_FILL = 3'd3,
      S_GAP     = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // Lane i of the enable drives byte (3-i) of the word: en[3] owns bits [7:0].
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  en);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) merged[8*(3-i) +: 8] = new_word[8*(3-i) +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line store: valid/tag/optional dirty per line, asynchronous read,
// byte-masked word write or whole-block fill on the rising edge.
module cache_line_array
   import cache_mgmt_unit_pkg::*;
#(
   parameter int IDX_W     = 6,
   parameter int TAG_W     = 21,
   parameter bit HAS_DIRTY = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    idx,
   input  logic [OFFSET_W-1:0] word_sel,
   input  logic [TAG_W-1:0]    tag_in,
   input  logic                word_we,
   input  logic [3:0]          byte_en,
   input  logic [31:0]         word_data,
   input  logic                block_we,
   input  logic [BLOCK_W-1:0]  block_data,
   input  logic                clear_dirty,
   output logic                valid,
   output logic                dirty,
   output logic [TAG_W-1:0]    tag,
   output logic [BLOCK_W-1:0]  block,
   output logic [31:0]         word
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [BLOCK_W-1:0] data_mem [LINES];

   assign valid = valid_q[idx];
   assign dirty = HAS_DIRTY ? dirty_q[idx] : 1'b0;
   assign tag   = tag_mem[idx];
   assign block = data_mem[idx];
   assign word  = block[{word_sel, 5'b0} +: 32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (block_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_we && HAS_DIRTY) begin
         dirty_q[idx] <= 1'b1;
      end else if (clear_dirty) begin
         dirty_q[idx] <= 1'b0;
      end
   end

   // Payload needs no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (block_we) begin
         data_mem[idx] <= block_data;
         tag_mem[idx]  <= tag_in;
      end else if (word_we) begin
         data_mem[idx][{word_sel, 5'b0} +: 32] <= merge_lanes(word, word_data, byte_en);
      end
   end

endmodule

// File: rtl/cache_mgmt_unit.sv
// Split I/D L1 controller sharing one block port to RAM; the D-cache is
// write-back/write-allocate and its misses win over simultaneous I misses.
module cache_mgmt_unit
   import cache_mgmt_unit_pkg::*;
#(
   parameter int IC_IDX_W = 6,
   parameter int DC_IDX_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ic_read_in,
   input  logic               dc_read_in,
   input  logic               dc_write_in,
   input  logic [3:0]         dc_byte_w_en_in,
   input  logic [29:0]        ic_addr,
   input  logic [29:0]        dc_addr,
   input  logic [31:0]        data_from_reg,
   input  logic               ram_ready,
   input  logic [BLOCK_W-1:0] block_from_ram,
   output logic               mem_stall,
   output logic [31:0]        dc_data_out,
   output logic [31:0]        ic_data_out,
   output logic [2:0]         status,
   output logic [2:0]         counter,
   output logic               ram_en_out,
   output logic               ram_write_out,
   output logic [29:0]        ram_addr_out,
   output logic [BLOCK_W-1:0] dc_data_wb
);

   localparam int IC_TAG_W = ADDR_W - OFFSET_W - IC_IDX_W;
   localparam int DC_TAG_W = ADDR_W - OFFSET_W - DC_IDX_W;

   state_t state_q, state_d;

   logic [IC_IDX_W-1:0] ic_idx;
   logic [IC_TAG_W-1:0] ic_tag, ic_line_tag;
   logic [DC_IDX_W-1:0] dc_idx;
   logic [DC_TAG_W-1:0] dc_tag, dc_line_tag;
   logic                ic_valid, dc_valid, dc_dirty, ic_dirty_unused;
   logic [BLOCK_W-1:0]  dc_block, ic_block_unused;
   logic                ic_miss, dc_miss, dc_req, ram_active;

   assign ic_idx = ic_addr[OFFSET_W +: IC_IDX_W];
   assign ic_tag = ic_addr[ADDR_W-1 -: IC_TAG_W];
   assign dc_idx = dc_addr[OFFSET_W +: DC_IDX_W];
   assign dc_tag = dc_addr[ADDR_W-1 -: DC_TAG_W];

   assign dc_req     = dc_read_in | dc_write_in;
   assign ic_miss    = ic_read_in & ~(ic_valid & (ic_line_tag == ic_tag));
   assign dc_miss    = dc_req & ~(dc_valid & (dc_line_tag == dc_tag));
   assign mem_stall  = (state_q != S_IDLE) | ic_miss | dc_miss;
   assign ram_active = (state_q == S_DC_WB) | (state_q == S_DC_FILL) | (state_q == S_IC_FILL);
   assign status     = state_q;

   cache_line_array #(.IDX_W(IC_IDX_W), .TAG_W(IC_TAG_W), .HAS_DIRTY(1'b0)) u_icache (
      .clk         (clk),
      .rst         (rst),
      .idx         (ic_idx),
      .word_sel    (ic_addr[OFFSET_W-1:0]),
      .tag_in      (ic_tag),
      .word_we     (1'b0),
      .byte_en     (4'b0000),
      .word_data   (32'h0),
      .block_we    ((state_q == S_IC_FILL) & ram_ready),
      .block_data  (block_from_ram),
      .clear_dirty (1'b0),
      .valid       (ic_valid),
      .dirty       (ic_dirty_unused),
      .tag         (ic_line_tag),
      .block       (ic_block_unused),
      .word        (ic_data_out)
   );

   // A store commits only on a cycle the pipeline is not frozen, so it lands exactly once.
   cache_line_array #(.IDX_W(DC_IDX_W), .TAG_W(DC_TAG_W), .HAS_DIRTY(1'b1)) u_dcache (
      .clk         (clk),
      .rst         (rst),
      .idx         (dc_idx),
      .word_sel    (dc_addr[OFFSET_W-1:0]),
      .tag_in      (dc_tag),
      .word_we     (dc_write_in & ~dc_miss & ~mem_stall),
      .byte_en     (dc_byte_w_en_in),
      .word_data   (data_from_reg),
      .block_we    ((state_q == S_DC_FILL) & ram_ready),
      .block_data  (block_from_ram),
      .clear_dirty ((state_q == S_DC_WB) & ram_ready),
      .valid       (dc_valid),
      .dirty       (dc_dirty),
      .tag         (dc_line_tag),
      .block       (dc_block),
      .word        (dc_data_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (dc_miss)      state_d = (dc_valid & dc_dirty) ? S_DC_WB : S_DC_FILL;
            else if (ic_miss) state_d = S_IC_FILL;
         end
         S_DC_WB:   if (ram_ready) state_d = S_GAP;
         S_GAP:     state_d = S_DC_FILL;
         S_DC_FILL: if (ram_ready) state_d = S_DONE;
         S_IC_FILL: if (ram_ready) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Request fields derive from inputs the frozen pipeline holds steady.
   always_comb begin
      ram_en_out    = 1'b0;
      ram_write_out = 1'b0;
      ram_addr_out  = '0;
      dc_data_wb    = '0;
      case (state_q)
         S_DC_WB: begin
            ram_en_out    = 1'b1;
            ram_write_out = 1'b1;
            ram_addr_out  = {dc_line_tag, dc_idx, 3'b000};
            dc_data_wb    = dc_block;
         end
         S_DC_FILL: begin
            ram_en_out   = 1'b1;
            ram_addr_out = {dc_addr[29:3], 3'b000};
         end
         S_IC_FILL: begin
            ram_en_out   = 1'b1;
            ram_addr_out = {ic_addr[29:3], 3'b000};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                           counter <= '0;
      else if (state_q == S_IDLE && state_d != S_IDLE)   counter <= '0;
      else if (ram_active && ram_ready && counter != 3'd7) counter <= counter + 3'd1;
   end

endmodule

// File: tb/tb_cache_mgmt_unit.sv
// Directed bench for cache_mgmt_unit: expected RAM requests and read data are
// queued by the driver and popped by a negedge monitor as the DUT presents them.
module tb_cache_mgmt_unit;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ic_read_in = 0, dc_read_in = 0, dc_write_in = 0;
   logic [3:0]   dc_byte_w_en_in = 0;
   logic [29:0]  ic_addr = 0, dc_addr = 0;
   logic [31:0]  data_from_reg = 0;
   logic         ram_ready = 0;
   logic [255:0] block_from_ram = 0;
   logic         mem_stall, ram_en_out, ram_write_out;
   logic [31:0]  dc_data_out, ic_data_out;
   logic [2:0]   status, counter;
   logic [29:0]  ram_addr_out;
   logic [255:0] dc_data_wb;

   int checks = 0;
   int errors = 0;

   logic [32:0]  exp_req_q[$];   // {status, write, addr}
   logic [255:0] exp_wb_q[$];
   logic [31:0]  exp_ic_q[$];
   logic [31:0]  exp_dc_q[$];
   logic         prev_en = 1'b0;

   cache_mgmt_unit dut (
      .clk(clk), .rst(rst), .ic_read_in(ic_read_in), .dc_read_in(dc_read_in),
      .dc_write_in(dc_write_in), .dc_byte_w_en_in(dc_byte_w_en_in),
      .ic_addr(ic_addr), .dc_addr(dc_addr), .data_from_reg(data_from_reg),
      .ram_ready(ram_ready), .block_from_ram(block_from_ram),
      .mem_stall(mem_stall), .dc_data_out(dc_data_out), .ic_data_out(ic_data_out),
      .status(status), .counter(counter), .ram_en_out(ram_en_out),
      .ram_write_out(ram_write_out), .ram_addr_out(ram_addr_out), .dc_data_wb(dc_data_wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] make_block(input logic [31:0] base);
      logic [255:0] b;
      for (int k = 0; k < 8; k++) b[32*k +: 32] = base + 32'(k);
      return b;
   endfunction

   // Monitor: RAM request starts and completed reads.
   always @(negedge clk) begin
      if (ram_en_out && !prev_en) begin
         if (exp_req_q.size() == 0) begin
            chk("unexpected_req", {223'h0, status, ram_write_out, ram_addr_out}, 256'h0);
         end else begin
            chk("ram_req", {223'h0, status, ram_write_out, ram_addr_out},
                {223'h0, exp_req_q.pop_front()});
            if (ram_write_out) begin
               if (exp_wb_q.size() == 0) chk("unexpected_wb", dc_data_wb, 256'h0);
               else                      chk("wb_block", dc_data_wb, exp_wb_q.pop_front());
            end
         end
      end
      prev_en = ram_en_out;
      if (ic_read_in && !mem_stall && exp_ic_q.size() > 0)
         chk("ic_data", {224'h0, ic_data_out}, {224'h0, exp_ic_q.pop_front()});
      if (dc_read_in && !mem_stall && exp_dc_q.size() > 0)
         chk("dc_data", {224'h0, dc_data_out}, {224'h0, exp_dc_q.pop_front()});
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Wait for a RAM request, then answer it with a one-cycle ram_ready.
   task automatic serve(input logic [255:0] blk);
      int n = 0;
      do begin @(negedge clk); n++; end while (!ram_en_out && n < 50);
      if (!ram_en_out) chk("serve_timeout", 256'h0, 256'h1);
      step();
      ram_ready = 1'b1;
      block_from_ram = blk;
      step();
      ram_ready = 1'b0;
      block_from_ram = '0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_req_q.size() + exp_wb_q.size() + exp_ic_q.size() + exp_dc_q.size()) != 0 && n < 40) begin
         @(negedge clk); n++;
      end
      chk("drain_pending", 256'(exp_req_q.size() + exp_wb_q.size() + exp_ic_q.size() + exp_dc_q.size()), 256'h0);
   endtask

   logic [255:0] b_ic, b1, b1_mod, b2, b3, b4;

   initial begin
      b_ic = make_block(32'h5000_0000);
      b_ic[31:0] = 32'hDEAD_BEEF;
      b1 = make_block(32'hA000_0000);
      b1[3*32 +: 32] = 32'h0;
      b1_mod = b1;
      b1_mod[3*32 +: 32] = 32'h0000_0044;
      b2 = make_block(32'hB000_0000);
      b3 = make_block(32'hC000_0000);
      b4 = make_block(32'hD000_0000);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_status",  256'(status), 256'h0);
      chk("rst_counter", 256'(counter), 256'h0);
      chk("rst_ram_en",  256'(ram_en_out), 256'h0);
      chk("rst_addr",    256'(ram_addr_out), 256'h0);
      chk("rst_wb",      dc_data_wb, 256'h0);
      chk("rst_stall",   256'(mem_stall), 256'h0);
      step();
      rst = 1'b0;
      step();

      // I-cache cold fetch
      exp_req_q.push_back({3'd3, 1'b0, 30'h10});
      exp_ic_q.push_back(32'hDEAD_BEEF);
      ic_addr = 30'h10;
      ic_read_in = 1'b1;
      @(negedge clk);
      chk("ic_miss_stall",  256'(mem_stall), 256'h1);
      chk("ic_miss_status", 256'(status), 256'h0);
      serve(b_ic);
      @(negedge clk);
      chk("ic_done_status", 256'(status), 256'h5);
      chk("ic_done_stall",  256'(mem_stall), 256'h1);
      chk("ic_done_en",     256'(ram_en_out), 256'h0);
      drain();
      ic_read_in = 1'b0;
      step();

      // D-cache cold load, then a hit on word 7 of the same block
      exp_req_q.push_back({3'd2, 1'b0, 30'h208});
      exp_dc_q.push_back(32'hA000_0000);
      dc_addr = 30'h208;
      dc_read_in = 1'b1;
      serve(b1);
      drain();
      step();
      exp_dc_q.push_back(32'hA000_0007);
      dc_addr = 30'h20F;
      @(negedge clk);
      chk("dc_hit_stall", 256'(mem_stall), 256'h0);
      drain();
      step();

      // Byte-lane store hit into a zero word
      dc_read_in = 1'b0;
      dc_write_in = 1'b1;
      dc_addr = 30'h20B;
      dc_byte_w_en_in = 4'b1000;
      data_from_reg = 32'h1122_3344;
      @(negedge clk);
      chk("store_stall", 256'(mem_stall), 256'h0);
      chk("store_before", 256'(dc_data_out), 256'h0);
      step();
      dc_write_in = 1'b0;
      dc_byte_w_en_in = 4'b0000;
      dc_read_in = 1'b1;
      exp_dc_q.push_back(32'h0000_0044);
      drain();
      step();

      // Conflict miss on a dirty line: write-back, gap, fill
      exp_req_q.push_back({3'd1, 1'b1, 30'h208});
      exp_wb_q.push_back(b1_mod);
      exp_req_q.push_back({3'd2, 1'b0, 30'h408});
      exp_dc_q.push_back(32'hB000_0000);
      dc_addr = 30'h408;
      serve(256'h0);
      @(negedge clk);
      chk("gap_status", 256'(status), 256'h4);
      chk("gap_en",     256'(ram_en_out), 256'h0);
      serve(b2);
      @(negedge clk);
      chk("wb_done_status",  256'(status), 256'h5);
      chk("wb_done_counter", 256'(counter), 256'h2);
      drain();
      dc_read_in = 1'b0;
      step();

      // Simultaneous I and D miss: D first, then I
      exp_req_q.push_back({3'd2, 1'b0, 30'h600});
      exp_req_q.push_back({3'd3, 1'b0, 30'h100});
      exp_dc_q.push_back(32'hC000_0000);
      exp_ic_q.push_back(32'hD000_0000);
      dc_addr = 30'h600;
      ic_addr = 30'h100;
      dc_read_in = 1'b1;
      ic_read_in = 1'b1;
      serve(b3);
      @(negedge clk);
      chk("dual_done_status", 256'(status), 256'h5);
      chk("dual_done_en",     256'(ram_en_out), 256'h0);
      @(negedge clk);
      chk("dual_idle_status", 256'(status), 256'h0);
      chk("dual_idle_stall",  256'(mem_stall), 256'h1);
      chk("dual_idle_en",     256'(ram_en_out), 256'h0);
      serve(b4);
      drain();
      dc_read_in = 1'b0;
      ic_read_in = 1'b0;
      step();

      // Reset in the middle of a fill
      exp_req_q.push_back({3'd2, 1'b0, 30'h808});
      dc_addr = 30'h808;
      dc_read_in = 1'b1;
      drain();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_en",     256'(ram_en_out), 256'h0);
      chk("midrst_status", 256'(status), 256'h0);
      chk("midrst_addr",   256'(ram_addr_out), 256'h0);
      step();
      dc_read_in = 1'b0;
      step();
      rst = 1'b0;
      ic_addr = 30'h10;
      ic_read_in = 1'b1;
      @(negedge clk);
      chk("post_rst_ic_miss", 256'(mem_stall), 256'h1);
      #1;
      ic_read_in = 1'b0;
      step();
      dc_addr = 30'h20F;
      dc_read_in = 1'b1;
      @(negedge clk);
      chk("post_rst_dc_miss", 256'(mem_stall), 256'h1);
      #1;
      dc_read_in = 1'b0;
      step();
      @(negedge clk);
      chk("post_rst_idle", 256'(status), 256'h0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cache_mgmt_unit.md
Name: cache_mgmt_unit

Overview:
- Split L1 cache controller between the pipeline and the block-oriented DDR controller: direct-mapped instruction cache plus direct-mapped write-back, write-allocate data cache.
- Services both caches through one shared 256-bit (8-word) block port to RAM.
- Raises mem_stall while any miss is in service.
- All addresses are 30-bit word addresses.

Parameters:
- IC_IDX_W, 6, I-cache index bits (64 lines).
- DC_IDX_W, 6, D-cache index bits (64 lines).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_read_in  in  1  instruction fetch request.
- dc_read_in  in  1  data load request.
- dc_write_in  in  1  data store request.
- dc_byte_w_en_in  in  4  store lane enables.
- ic_addr  in  30  fetch word address.
- dc_addr  in  30  data word address.
- data_from_reg  in  32  store data.
- ram_ready  in  1  RAM transaction complete (1-cycle pulse).
- block_from_ram  in  256  fill block, valid while ram_ready=1.
- mem_stall  out  1  freeze pipeline.
- dc_data_out  out  32  load data.
- ic_data_out  out  32  fetched instruction.
- status  out  3  FSM state (debug).
- counter  out  3  RAM transactions done in current miss (debug).
- ram_en_out  out  1  RAM request.
- ram_write_out  out  1  1 = write-back, 0 = fill.
- ram_addr_out  out  30  block-aligned word address, bits[2:0]=0.
- dc_data_wb  out  256  victim block for write-back.

Behaviour:
- Address split: offset=addr[2:0] (word in block); index=next IDX_W bits; tag=the remaining upper bits. Block word k sits at bits [32k+31:32k].
- Per line: valid bit and tag; D-cache also holds a dirty bit. Arrays read asynchronously and written on the rising clk edge.
- Hit = request && valid[index] && tag match. ic_data_out and dc_data_out always show the addressed word of the indexed line, combinationally, hit or not.
- Store hit:
  - Updates the word at the clk edge where mem_stall=0 and sets dirty.
  - Lane mapping: en[3]→bits[7:0], en[2]→[15:8], en[1]→[23:16], en[0]→[31:24].
  - Only enabled lanes are written.
- mem_stall = (status!=IDLE) | (ic_read_in & ic miss) | ((dc_read_in|dc_write_in) & dc miss). It is combinational.
- FSM states and encodings:
  - IDLE=0: on the D miss, go to DC_WB if the victim is valid && dirty, else to DC_FILL. Else on the I miss, go to IC_FILL. The D miss has priority when both miss.
  - DC_WB=1: ram_en_out=1, ram_write_out=1, ram_addr_out={victim tag,index,3'b0}, dc_data_wb=victim line. On ram_ready, clear dirty and go to GAP then DC_FILL.
  - DC_FILL=2: ram_en_out=1, ram_write_out=0, ram_addr_out={dc_addr[29:3],3'b0}. On ram_ready, write block_from_ram, tag, valid=1, dirty=0, then go to DONE.
  - IC_FILL=3: same as DC_FILL using ic_addr, into the I-cache, then go to DONE.
  - GAP=4: one cycle with ram_en_out=0, then go to DC_FILL.
  - DONE=5: one cycle with ram_en_out=0 and mem_stall still 1, then go to IDLE. The access is re-evaluated and now hits; a pending store performs its write then. A pending I miss, if any, is serviced next.
- ram_en_out, ram_write_out, ram_addr_out and dc_data_wb are held stable for the whole request until ram_ready. ram_en_out is low for at least one cycle between requests.
- counter: cleared on leaving IDLE; increments on each ram_ready; saturates at 7.
- Reset (any time, including mid-miss) gives: all valid/dirty=0, status=IDLE, counter=0, ram_en_out=0, ram_write_out=0, ram_addr_out=0, dc_data_wb=0. An in-flight RAM request is abandoned.
- ram_ready outside DC_WB/DC_FILL/IC_FILL is ignored.
- No request asserted gives no stall. dc_read_in and dc_write_in both high is treated as a store.

Decomposition:
- Shared package: state encodings (IDLE..DONE), BLOCK_W=256, WORDS_PER_BLOCK=8, OFFSET_W=3.
- One natural sub-module, cache_line_array: parameterised tag/valid/data array with async read and byte-lane-masked word write or full-block write. Instantiate it twice; the D-cache instance has the dirty bit enabled.

Test Plan:
- Reset, then fetch ic_addr=0x10 → mem_stall=1, status=3, ram_en_out=1, ram_addr_out=0x10, ram_write_out=0. Pulse ram_ready with word0=0xDEADBEEF → after DONE, stall=0 and ic_data_out=0xDEADBEEF.
- Load dc_addr=0x208 with a cold cache → DC_FILL at ram_addr_out=0x208. Then load dc_addr=0x20F → hit, no stall, word7 of the block returned.
- Store 0x11223344 with en=4'b1000 to a cached word holding 0 → dc_data_out=0x00000044 next cycle, line dirty.
- Load a conflicting address (same index, different tag) → DC_WB with dc_data_wb containing the modified word and the old block address, then GAP, then DC_FILL of the new block; counter=2 at DONE.
- I and D miss in the same cycle → D serviced first (status 2), then I (status 3); two ram_en pulses separated by low ram_en_out.
- Assert rst during DC_FILL → ram_en_out=0 and status=0 immediately; prior hits now miss.
